// File: rtl/fir_pkg.sv
// Shared definitions for the FIR accelerator front end: default sample
// geometry, the ingest state encoding and the Q-format saturating converter.
package fir_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_Q_FORMAT   = 8;
    localparam int DEF_RAW_WIDTH  = 12;
    localparam int DEF_SCALE      = 1 << DEF_Q_FORMAT;

    localparam longint SAT_MAX = (longint'(1) <<< (DEF_DATA_WIDTH - 1)) - 1;
    localparam longint SAT_MIN = -(longint'(1) <<< (DEF_DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } ingest_state_t;

    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] val;
        logic                             sat;
    } sat_t;

    // Sign-extend, scale to Q-format and clamp into the signed output range.
    function automatic sat_t sat_q(input logic signed [DEF_RAW_WIDTH-1:0] raw);
        longint wide;
        sat_t   res;
        wide = longint'(raw) <<< DEF_Q_FORMAT;
        if (wide > SAT_MAX) begin
            res.val = DEF_DATA_WIDTH'(SAT_MAX);
            res.sat = 1'b1;
        end else if (wide < SAT_MIN) begin
            res.val = DEF_DATA_WIDTH'(SAT_MIN);
            res.sat = 1'b1;
        end else begin
            res.val = DEF_DATA_WIDTH'(wide);
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_sample_ingest_if.sv
// Sensor-in / sample-out handshake bundle of the ingest stage.
// master: the ingest block; slave: sensor source plus FIR consumer.
interface fir_sample_ingest_if
    import fir_pkg::*;
#(
    parameter int RAW_WIDTH  = DEF_RAW_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic signed [RAW_WIDTH-1:0]  rawSensorVal;
    logic                         rawValid;
    logic signed [DATA_WIDTH-1:0] sampleOut;
    logic                         sampleValid;
    logic                         sampleReady;

    modport master (
        input  rawSensorVal,
        input  rawValid,
        input  sampleReady,
        output sampleOut,
        output sampleValid
    );

    modport slave (
        output rawSensorVal,
        output rawValid,
        output sampleReady,
        input  sampleOut,
        input  sampleValid
    );
endinterface

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. flush wins over a
// same-cycle push or pop. DEPTH must be a power of two so pointers wrap freely.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Next pointers and count; flush discards any same-cycle push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; data only, never reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/fir_sample_ingest.sv
// Ingest stage of the FIR accelerator: converts raw sensor samples to
// saturated Q-format, buffers them, and streams them once the buffer is primed.
// Optional build macro INGEST_DROP_COUNT_EN adds the saturating dropCount port.
module fir_sample_ingest
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int Q_FORMAT    = DEF_Q_FORMAT,
    parameter int RAW_WIDTH   = DEF_RAW_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          accelerateEn,
    input  logic                          flush,
    fir_sample_ingest_if.master           bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          satEvent,
    output logic                          overflow
`ifdef INGEST_DROP_COUNT_EN
    ,
    output logic [7:0]                    dropCount
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // The converter lives in the shared package at its default geometry.
    if (Q_FORMAT != DEF_Q_FORMAT || DATA_WIDTH != DEF_DATA_WIDTH ||
        RAW_WIDTH != DEF_RAW_WIDTH) begin : g_cfg_check
        $error("fir_sample_ingest: conversion geometry must match fir_pkg defaults");
    end

    ingest_state_t               state_q, state_d;
    logic                        overflow_q, overflow_d;
    logic                        sat_event_q, sat_event_d;
    logic signed [RAW_WIDTH-1:0] raw_in;
    sat_t                        conv;
    logic [DATA_WIDTH-1:0]       fifo_rdata;
    logic [CW-1:0]               fifo_count;
    logic                        fifo_full, fifo_empty;
    logic                        sample_valid, pop, ingest_on, push_ok, accept, drop;

    assign raw_in       = bus.rawSensorVal;
    assign conv         = sat_q(raw_in);
    assign sample_valid = (state_q == STREAM) && !fifo_empty;
    assign pop          = sample_valid && bus.sampleReady;
    assign ingest_on    = bus.rawValid && (state_q != IDLE);
    assign push_ok      = ingest_on && (!fifo_full || pop);
    assign accept       = push_ok && !flush;
    assign drop         = ingest_on && !push_ok && !flush;

    // Output is forced to zero when not valid so reset shows a clean bus.
    assign bus.sampleValid = sample_valid;
    assign bus.sampleOut   = sample_valid ? fifo_rdata : '0;
    assign fifoCount       = fifo_count;
    assign satEvent        = sat_event_q;
    assign overflow        = overflow_q;

    fir_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_ok),
        .pop   (pop),
        .wdata (conv.val),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Prime/stream sequencing; disable always wins, flush restarts priming.
    always_comb begin
        state_d = state_q;
        if (!accelerateEn) begin
            state_d = IDLE;
        end else if (flush) begin
            state_d = PRIME;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (fifo_count >= CW'(PRIME_LEVEL)) state_d = STREAM;
                STREAM:  state_d = STREAM;
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky overflow and one-cycle saturation pulse.
    always_comb begin
        overflow_d  = overflow_q;
        sat_event_d = 1'b0;
        if (flush) begin
            overflow_d = 1'b0;
        end else begin
            if (drop)   overflow_d  = 1'b1;
            if (accept) sat_event_d = conv.sat;
        end
    end

    // State and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            overflow_q  <= 1'b0;
            sat_event_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            sat_event_q <= sat_event_d;
        end
    end

`ifdef INGEST_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Count dropped samples, holding at 255.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush)                          drop_cnt_d = '0;
        else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign dropCount = drop_cnt_q;
`endif
endmodule

// File: tb/tb_fir_sample_ingest.sv
// Scoreboard bench for fir_sample_ingest: a queue-based reference model is
// updated on every clock; a negedge monitor compares the DUT against it.
module tb_fir_sample_ingest;
    logic       clk = 1'b0;
    logic       rst;
    logic       accelerateEn;
    logic       flush;
    logic [2:0] fifoCount;
    logic       satEvent;
    logic       overflow;
`ifdef INGEST_DROP_COUNT_EN
    logic [7:0] dropCount;
`endif

    fir_sample_ingest_if #(.RAW_WIDTH(12), .DATA_WIDTH(16)) bus ();

    fir_sample_ingest #(
        .DATA_WIDTH  (16),
        .Q_FORMAT    (8),
        .RAW_WIDTH   (12),
        .FIFO_DEPTH  (4),
        .PRIME_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .accelerateEn (accelerateEn),
        .flush        (flush),
        .bus          (bus),
        .fifoCount    (fifoCount),
        .satEvent     (satEvent),
        .overflow     (overflow)
`ifdef INGEST_DROP_COUNT_EN
        ,
        .dropCount    (dropCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: 0 = idle, 1 = priming, 2 = streaming
    int m_state;
    int m_q[$];
    bit m_ovf;
    int m_drop;
    bit m_sat;
    int md_sz;
    bit md_pop;
    bit md_in;
    int md_raw;

    int got[$];

    function automatic int q8_conv(input int r);
        int v = r * 256;
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit q8_sat(input int r);
        int v = r * 256;
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        bus.rawSensorVal = 12'(v);
        bus.rawValid     = 1'b1;
        step();
        bus.rawValid     = 1'b0;
    endtask

    task automatic check_got(input string name, input int exp[$]);
        check({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(name, got[i], exp[i]);
    endtask

    // Behavioural reference: a queue of converted samples plus mode/flags.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_sat   = 1'b0;
        end else begin
            md_sz  = m_q.size();
            md_pop = (m_state == 2) && (md_sz > 0) && bus.sampleReady;
            md_in  = bus.rawValid && (m_state != 0);
            if (flush) begin
                m_q.delete();
                m_ovf   = 1'b0;
                m_drop  = 0;
                m_sat   = 1'b0;
                m_state = accelerateEn ? 1 : 0;
            end else begin
                m_sat = 1'b0;
                if (md_pop) void'(m_q.pop_front());
                if (md_in) begin
                    md_raw = int'(bus.rawSensorVal);
                    if (md_sz < 4 || md_pop) begin
                        m_q.push_back(q8_conv(md_raw));
                        m_sat = q8_sat(md_raw);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop < 255) m_drop++;
                    end
                end
                if (!accelerateEn)                 m_state = 0;
                else if (m_state == 0)             m_state = 1;
                else if (m_state == 1 && md_sz >= 2) m_state = 2;
            end
        end
    end

    // Monitor: compare DUT against the model and log delivered samples.
    always @(negedge clk) begin
        check("valid", int'(bus.sampleValid), int'(m_state == 2 && m_q.size() > 0));
        if (bus.sampleValid && m_q.size() > 0)
            check("data", int'(bus.sampleOut), m_q[0]);
        check("count", int'(fifoCount), m_q.size());
        check("overflow", int'(overflow), int'(m_ovf));
        check("satEvent", int'(satEvent), int'(m_sat));
`ifdef INGEST_DROP_COUNT_EN
        check("dropCount", int'(dropCount), m_drop);
`endif
        if (!rst && !flush && bus.sampleValid && bus.sampleReady)
            got.push_back(int'(bus.sampleOut));
    end

    initial begin
        rst              = 1'b1;
        accelerateEn     = 1'b0;
        flush            = 1'b0;
        bus.rawValid     = 1'b0;
        bus.rawSensorVal = '0;
        bus.sampleReady  = 1'b0;
        step();
        step();
        check("rst_out", int'(bus.sampleOut), 0);
        check("rst_valid", int'(bus.sampleValid), 0);
        check("rst_count", int'(fifoCount), 0);
        rst = 1'b0;

        // priming then streaming 3, 5, 7
        accelerateEn    = 1'b1;
        bus.sampleReady = 1'b1;
        step();
        got.delete();
        push(3);
        push(5);
        check("prime_hold", int'(bus.sampleValid), 0);
        push(7);
        check("stream_start", int'(bus.sampleValid), 1);
        check("stream_head", int'(bus.sampleOut), 'h0300);
        repeat (5) step();
        check_got("prime_seq", '{'h0300, 'h0500, 'h0700});

        // saturation both directions
        got.delete();
        push(200);
        check("sat_hi_pulse", int'(satEvent), 1);
        push(-300);
        check("sat_lo_pulse", int'(satEvent), 1);
        step();
        check("sat_pulse_end", int'(satEvent), 0);
        repeat (3) step();
        check_got("sat_seq", '{32767, -32768});

        // overflow with back-pressure
        bus.sampleReady = 1'b0;
        for (int i = 1; i <= 6; i++) push(i);
        check("ovf_count", int'(fifoCount), 4);
        check("ovf_flag", int'(overflow), 1);
`ifdef INGEST_DROP_COUNT_EN
        check("ovf_drops", int'(dropCount), 2);
`endif
        got.delete();
        bus.sampleReady = 1'b1;
        repeat (6) step();
        check_got("ovf_seq", '{'h0100, 'h0200, 'h0300, 'h0400});

        // full FIFO with simultaneous push and pop
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_ovf_clr", int'(overflow), 0);
        bus.sampleReady = 1'b0;
        for (int i = 1; i <= 4; i++) push(i);
        check("full_count", int'(fifoCount), 4);
        got.delete();
        bus.sampleReady  = 1'b1;
        bus.rawSensorVal = 12'sd9;
        bus.rawValid     = 1'b1;
        step();
        bus.rawValid    = 1'b0;
        bus.sampleReady = 1'b0;
        check("pp_count", int'(fifoCount), 4);
        check("pp_no_ovf", int'(overflow), 0);
        bus.sampleReady = 1'b1;
        repeat (7) step();
        check_got("pp_seq", '{'h0100, 'h0200, 'h0300, 'h0400, 'h0900});

        // flush beats a same-cycle push
        bus.sampleReady = 1'b0;
        push(1);
        push(2);
        push(3);
        check("pre_flush_count", int'(fifoCount), 3);
        flush            = 1'b1;
        bus.rawSensorVal = 12'sd4;
        bus.rawValid     = 1'b1;
        step();
        flush        = 1'b0;
        bus.rawValid = 1'b0;
        check("flush_count", int'(fifoCount), 0);
        check("flush_valid", int'(bus.sampleValid), 0);
        step();
        check("flush_no_store", int'(fifoCount), 0);
        bus.sampleReady = 1'b1;
        push(5);
        check("flush_in_prime", int'(bus.sampleValid), 0);
        push(6);
        step();
        check("reprime_head", int'(bus.sampleOut), 'h0500);
        repeat (4) step();

        // async reset mid-stream
        bus.sampleReady = 1'b0;
        push(1);
        push(2);
        check("pre_rst_valid", int'(bus.sampleValid), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(bus.sampleValid), 0);
        check("async_rst_count", int'(fifoCount), 0);
        step();
        rst = 1'b0;

        // enable drop keeps contents, re-enable re-primes from them
        step();
        push(1);
        push(2);
        step();
        check("en_stream", int'(bus.sampleValid), 1);
        accelerateEn = 1'b0;
        step();
        check("dis_valid", int'(bus.sampleValid), 0);
        bus.rawSensorVal = 12'sd7;
        bus.rawValid     = 1'b1;
        repeat (3) step();
        bus.rawValid = 1'b0;
        check("dis_count", int'(fifoCount), 2);
        check("dis_no_ovf", int'(overflow), 0);
        accelerateEn = 1'b1;
        step();
        check("reen_prime", int'(bus.sampleValid), 0);
        step();
        check("reen_stream", int'(bus.sampleValid), 1);
        check("reen_head", int'(bus.sampleOut), 'h0100);
        bus.sampleReady = 1'b1;
        repeat (4) step();

        // long drop run to reach the drop-counter ceiling
        flush = 1'b1;
        step();
        flush           = 1'b0;
        bus.sampleReady = 1'b0;
        bus.rawValid    = 1'b1;
        repeat (300) begin
            bus.rawSensorVal = 12'($urandom);
            step();
        end
        bus.rawValid = 1'b0;
        check("long_ovf", int'(overflow), 1);
        check("long_count", int'(fifoCount), 4);
`ifdef INGEST_DROP_COUNT_EN
        check("drop_ceiling", int'(dropCount), 255);
`endif

        // randomized traffic
        repeat (3000) begin
            accelerateEn     = ($urandom_range(31) != 0);
            flush            = ($urandom_range(47) == 0);
            bus.sampleReady  = ($urandom_range(3) != 0);
            bus.rawValid     = ($urandom_range(2) != 0);
            bus.rawSensorVal = $urandom_range(1) ? 12'($urandom)
                                                 : 12'($urandom_range(255)) - 12'd128;
            step();
        end
        accelerateEn    = 1'b1;
        flush           = 1'b0;
        bus.rawValid    = 1'b0;
        bus.sampleReady = 1'b1;
        repeat (10) step();
        check("drain_count", int'(fifoCount), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
